// File: rtl/bcd_stopwatch_up_pkg.sv
// Shared types and constants for the BCD up-counting stopwatch.
// Consumers: bcd_digit_up, bcd_stopwatch_up_if, bcd_stopwatch_up.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } sw_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Decimal successor of one digit: 9 rolls over to 0.
   function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
      return (d == BCD_MAX) ? BCD_ZERO : d + 4'd1;
   endfunction

endpackage

// File: rtl/bcd_stopwatch_up_if.sv
// Control/status bundle of the stopwatch. The master drives tick and the control
// pulses and observes the results; the slave (the stopwatch) drives count, display and flags.
interface bcd_stopwatch_up_if #(parameter int DIGITS = 4);
   import bcd_pkg::*;

   logic                  tick;
   logic                  start;
   logic                  stop;
   logic                  sclr;
   logic                  lap;
   logic [4*DIGITS-1:0]   count;
   logic [4*DIGITS-1:0]   display;
   logic                  running;
   logic                  tc;
   logic                  full;
   sw_state_t             state;

   modport master (
      output tick, start, stop, sclr, lap,
      input  count, display, running, tc, full, state
   );

   modport slave (
      input  tick, start, stop, sclr, lap,
      output count, display, running, tc, full, state
   );

endinterface

// File: rtl/bcd_stopwatch_up_digit.sv
// One decimal digit of the stopwatch: increments on inc, wraps 9 -> 0, and
// flags max when it sits at 9 so the next digit up can be enabled.
module bcd_digit_up
   import bcd_pkg::*;
(
   input  logic       clock,
   input  logic       clr,
   input  logic       sclr,
   input  logic       inc,
   output bcd_digit_t q,
   output logic       max
);

   always_ff @(posedge clock or posedge clr) begin
      if (clr)
         q <= BCD_ZERO;
      else if (sclr)
         q <= BCD_ZERO;
      else if (inc)
         q <= bcd_inc(q);
   end

   assign max = (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch_up.sv
// Multi-digit BCD up-counting stopwatch with run/pause/lap control.
// Build option: define BCD_WRAP_EN to wrap at all-9s instead of saturating with full.
module bcd_stopwatch_up
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic            clock,
   input  logic            clr,
   bcd_stopwatch_up_if.slave sw
);

   sw_state_t             state;
   logic                  running_r;
   logic [4*DIGITS-1:0]   count_w;
   logic [4*DIGITS-1:0]   count_nxt;
   logic [4*DIGITS-1:0]   display_r;
   logic [DIGITS-1:0]     max_v;
   logic [DIGITS-1:0]     inc_v;
   logic [DIGITS:0]       chain;
   logic                  counting;
   logic                  all9;
   logic                  adv;
   logic                  count_en;
   logic                  full_r;
   logic                  tc_w;

   assign counting = (state == RUN) || (state == LAP);
   assign all9     = &max_v;
   assign adv      = sw.tick && counting && !full_r;
   assign tc_w     = all9 && adv;

`ifdef BCD_WRAP_EN
   assign count_en = adv && !sw.sclr;
   assign full_r   = 1'b0;
`else
   // Saturating build: the terminal tick must not roll the digits over.
   assign count_en = adv && !sw.sclr && !all9;

   always_ff @(posedge clock or posedge clr) begin
      if (clr)
         full_r <= 1'b0;
      else if (sw.sclr)
         full_r <= 1'b0;
      else if (tc_w)
         full_r <= 1'b1;
   end
`endif

   // Carry chain: digit i advances only when every lower digit is at 9.
   assign chain[0] = count_en;

   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_digit
         assign inc_v[i]    = chain[i];
         assign chain[i+1]  = chain[i] && max_v[i];
         assign count_nxt[4*i +: 4] = inc_v[i] ? bcd_inc(count_w[4*i +: 4])
                                               : count_w[4*i +: 4];

         bcd_digit_up u_digit (
            .clock (clock),
            .clr   (clr),
            .sclr  (sw.sclr),
            .inc   (inc_v[i]),
            .q     (count_w[4*i +: 4]),
            .max   (max_v[i])
         );
      end
   endgenerate

   // Display follows the post-update count, frozen while the current state is LAP.
   always_ff @(posedge clock or posedge clr) begin
      if (clr)
         display_r <= '0;
      else if (sw.sclr)
         display_r <= '0;
      else if (state != LAP)
         display_r <= count_nxt;
   end

   // Control FSM; only the highest-priority asserted control is considered.
   always_ff @(posedge clock or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         running_r <= 1'b0;
      end else if (sw.sclr) begin
         state     <= IDLE;
         running_r <= 1'b0;
      end else if (sw.stop) begin
         if (counting) begin
            state     <= PAUSE;
            running_r <= 1'b0;
         end
      end else if (sw.start) begin
         if (!counting) begin
            state     <= RUN;
            running_r <= 1'b1;
         end
      end else if (sw.lap) begin
         if (state == RUN)
            state <= LAP;
         else if (state == LAP)
            state <= RUN;
      end
   end

   assign sw.count   = count_w;
   assign sw.display = display_r;
   assign sw.running = running_r;
   assign sw.tc      = tc_w;
   assign sw.full    = full_r;
   assign sw.state   = state;

endmodule

// File: tb/tb_bcd_stopwatch_up.sv
// Directed self-checking bench for bcd_stopwatch_up (DIGITS=4); expectations
// follow BCD_WRAP_EN when the bench is built with it.
module tb_bcd_stopwatch_up;
   import bcd_pkg::*;

   localparam int DIGITS = 4;

   logic clock;
   logic clr;
   int   checks;
   int   errors;

   bcd_stopwatch_up_if #(.DIGITS(DIGITS)) sw ();

   bcd_stopwatch_up #(.DIGITS(DIGITS)) dut (
      .clock (clock),
      .clr   (clr),
      .sw    (sw)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Driver tasks: inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic run_ticks(input int n);
      sw.tick = 1'b1;
      repeat (n) step();
      sw.tick = 1'b0;
   endtask

   task automatic pulse_ctl(input logic st, input logic sp, input logic sc, input logic lp);
      sw.start = st;
      sw.stop  = sp;
      sw.sclr  = sc;
      sw.lap   = lp;
      step();
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      sw.sclr  = 1'b0;
      sw.lap   = 1'b0;
   endtask

   // Scoreboard comparison
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      sw.tick  = 1'b0;
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      sw.sclr  = 1'b0;
      sw.lap   = 1'b0;
      clr      = 1'b1;
      #2;
      check("rst_count",   sw.count,   32'h0);
      check("rst_display", sw.display, 32'h0);
      check("rst_running", sw.running, 32'h0);
      check("rst_tc",      sw.tc,      32'h0);
      check("rst_full",    sw.full,    32'h0);
      check("rst_state",   sw.state,   IDLE);
      clr = 1'b0;

      // 1. start then 12 ticks
      sw.tick = 1'b1;
      step();
      sw.tick = 1'b0;
      check("idle_tick_ignored", sw.count, 32'h0);
      pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      check("start_running", sw.running, 32'h1);
      check("start_state",   sw.state,   RUN);
      run_ticks(12);
      check("t1_count", sw.count, 32'h0012);
      step();
      check("t1_display", sw.display, 32'h0012);
      check("t1_count_hold", sw.count, 32'h0012);

      // 2. two-digit carry
      run_ticks(87);
      check("t2_count99", sw.count, 32'h0099);
      sw.tick = 1'b1;
      #1;
      check("t2_tc", sw.tc, 32'h0);
      step();
      sw.tick = 1'b0;
      check("t2_count100", sw.count, 32'h0100);

      // 3. terminal count
      sw.tick = 1'b1;
      repeat (9899) step();
      check("t3_count9999", sw.count, 32'h9999);
      check("t3_tc", sw.tc, 32'h1);
      step();
`ifdef BCD_WRAP_EN
      check("t3_wrap_count", sw.count, 32'h0000);
      check("t3_wrap_full",  sw.full,  32'h0);
      step();
      check("t3_wrap_continue", sw.count, 32'h0001);
`else
      check("t3_sat_count", sw.count, 32'h9999);
      check("t3_sat_full",  sw.full,  32'h1);
      check("t3_sat_tc",    sw.tc,    32'h0);
      step();
      check("t3_sat_hold",  sw.count, 32'h9999);
      check("t3_sat_state", sw.state, RUN);
`endif
      sw.tick = 1'b0;
      pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0);
      check("sclr_count",   sw.count,   32'h0);
      check("sclr_display", sw.display, 32'h0);
      check("sclr_full",    sw.full,    32'h0);
      check("sclr_state",   sw.state,   IDLE);

      // 4. lap hold
      pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      run_ticks(40);
      check("t4_count40", sw.count, 32'h0040);
      pulse_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      check("t4_lap_state",   sw.state,   LAP);
      check("t4_lap_running", sw.running, 32'h1);
      run_ticks(25);
      check("t4_lap_count",   sw.count,   32'h0065);
      check("t4_lap_display", sw.display, 32'h0040);
      pulse_ctl(1'b0, 1'b0, 1'b0, 1'b1);
      check("t4_release_state", sw.state,   RUN);
      check("t4_release_hold",  sw.display, 32'h0040);
      step();
      check("t4_release_track", sw.display, 32'h0065);

      // 5. priority
      pulse_ctl(1'b0, 1'b0, 1'b1, 1'b0);
      pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      run_ticks(7);
      check("t5_count7", sw.count, 32'h0007);
      pulse_ctl(1'b1, 1'b1, 1'b1, 1'b0);
      check("t5_sclr_wins_count", sw.count, 32'h0);
      check("t5_sclr_wins_state", sw.state, IDLE);
      pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      pulse_ctl(1'b1, 1'b1, 1'b0, 1'b0);
      check("t5_stop_wins_state",   sw.state,   PAUSE);
      check("t5_stop_wins_running", sw.running, 32'h0);
      sw.tick = 1'b1;
      #1;
      check("t5_pause_tc", sw.tc, 32'h0);
      step();
      sw.tick = 1'b0;
      check("t5_pause_count", sw.count, 32'h0);

      // 6. asynchronous clear mid-run
      pulse_ctl(1'b1, 1'b0, 1'b0, 1'b0);
      run_ticks(555);
      check("t6_count555", sw.count, 32'h0555);
      #2;
      clr = 1'b1;
      #1;
      check("t6_async_count",   sw.count,   32'h0);
      check("t6_async_display", sw.display, 32'h0);
      check("t6_async_running", sw.running, 32'h0);
      check("t6_async_full",    sw.full,    32'h0);
      check("t6_async_state",   sw.state,   IDLE);
      #2;
      clr = 1'b0;
      step();
      check("t6_after_clr", sw.count, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
